// File: rtl/cordic_result_logger_if.sv
// Result-side bus of the CORDIC logger: capture handshake toward the core
// and byte stream toward the UART transmitter.
//   data_in/data_valid/capture_ready : result words into the logger
//   tx_data/tx_valid/tx_ready        : bytes out to the UART transmitter
// master = harness side (core + UART), slave = logger.
interface cordic_result_logger_if #(
   parameter int unsigned W = 32
);
   logic [W-1:0] data_in;
   logic         data_valid;
   logic         capture_ready;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;

   modport master (
      output data_in,
      output data_valid,
      output tx_ready,
      input  capture_ready,
      input  tx_data,
      input  tx_valid
   );

   modport slave (
      input  data_in,
      input  data_valid,
      input  tx_ready,
      output capture_ready,
      output tx_data,
      output tx_valid
   );
endinterface

// File: rtl/cordic_result_logger.sv
// Capture-and-dump buffer for CORDIC results. Stores each W-bit result into
// a 2^AW-word RAM at an auto-incrementing address; on dump_start it streams
// the stored words MSB byte first over a valid/ready byte handshake.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : data_in/data_valid/capture_ready, tx_data/tx_valid/tx_ready
//   dump_start  : single-cycle request to stream the buffer out
//   count       : number of stored words, 0..2^AW
//   full        : count == 2^AW
//   busy        : dump in progress
module cordic_result_logger #(
   parameter int unsigned W  = 32,
   parameter int unsigned AW = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cordic_result_logger_if.slave bus,
   input  logic                  dump_start,
   output logic [AW:0]           count,
   output logic                  full,
   output logic                  busy
);

   localparam int unsigned NB    = W / 8;
   localparam int unsigned KW    = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned DEPTH = 1 << AW;

   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [KW-1:0] LAST_K    = KW'(NB - 1);

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      READ    = 2'd1,
      SEND    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [AW-1:0] last_q, last_d;
   logic [KW-1:0] k_q, k_d;
   logic [W-1:0]  word_q;
   logic          tx_valid_q;
   logic          full_q;
   logic          busy_q;
   logic          cap_rdy_q;

   logic          we_c;
   logic          load_c;
   logic          shift_c;
   logic [AW:0]   eff_count_c;

   logic [W-1:0]  mem [DEPTH];

   // Result RAM: no reset so contents survive reset and dumps.
   always_ff @(posedge clk) begin
      if (we_c) begin
         mem[count_q[AW-1:0]] <= bus.data_in;
      end
   end

   // Capture only while in CAPTURE and not full (cap_rdy_q encodes both).
   assign we_c        = bus.data_valid && cap_rdy_q;
   assign eff_count_c = count_q + (AW+1)'(we_c);

   // State register and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CAPTURE;
         count_q    <= '0;
         rd_addr_q  <= '0;
         last_q     <= '0;
         k_q        <= '0;
         word_q     <= '0;
         tx_valid_q <= 1'b0;
         full_q     <= 1'b0;
         busy_q     <= 1'b0;
         cap_rdy_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_addr_q  <= rd_addr_d;
         last_q     <= last_d;
         k_q        <= k_d;
         tx_valid_q <= (state_d == SEND);
         full_q     <= (count_d == DEPTH_CNT);
         busy_q     <= (state_d != CAPTURE);
         cap_rdy_q  <= (state_d == CAPTURE) && (count_d != DEPTH_CNT);
         // Output word: loaded by the READ cycle, shifted left one byte per
         // handshake so the current byte is always the top byte.
         if (load_c) begin
            word_q <= mem[rd_addr_q];
         end else if (shift_c) begin
            word_q <= word_q << 8;
         end
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rd_addr_d = rd_addr_q;
      last_d    = last_q;
      k_d       = k_q;
      load_c    = 1'b0;
      shift_c   = 1'b0;

      unique case (state_q)
         CAPTURE: begin
            count_d = eff_count_c;
            // A write in the same cycle as dump_start is part of the dump.
            if (dump_start && (eff_count_c != '0)) begin
               last_d    = AW'(eff_count_c - (AW+1)'(1));
               rd_addr_d = '0;
               k_d       = '0;
               state_d   = READ;
            end
         end
         READ: begin
            load_c  = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (bus.tx_ready) begin
               shift_c = 1'b1;
               if (k_q == LAST_K) begin
                  k_d = '0;
                  if (rd_addr_q == last_q) begin
                     count_d = '0;
                     state_d = CAPTURE;
                  end else begin
                     rd_addr_d = rd_addr_q + AW'(1);
                     state_d   = READ;
                  end
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         default: begin
            state_d = CAPTURE;
         end
      endcase
   end

   assign bus.capture_ready = cap_rdy_q;
   assign bus.tx_valid      = tx_valid_q;
   assign bus.tx_data       = word_q[W-1 -: 8];
   assign count             = count_q;
   assign full              = full_q;
   assign busy              = busy_q;

endmodule

// File: doc/cordic_result_logger.md
# cordic_result_logger

Capture-and-dump buffer on the result side of the hyperbolic CORDIC UART test harness. The test-vector ROM supplies operands to the CORDIC core. This block is the writer at the other end: it stores each W-bit CORDIC result into an internal 2^AW-word RAM at an auto-incrementing address. On request, it streams the stored words to the UART transmitter as bytes, MSB byte first, over a valid/ready handshake.

## Interface
- W, 32, result word width; must be a multiple of 8 (W/8 bytes per word)
- AW, 10, RAM address width; depth = 2^AW words (1024 by default)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- data_in  in  W  CORDIC result word
- data_valid  in  1  data_in is valid this cycle; written only if capture_ready=1
- capture_ready  out  1  block accepts results (CAPTURE state and not full)
- dump_start  in  1  single-cycle request to stream the buffer out
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART transmitter accepts the byte
- count  out  AW+1  number of stored words, 0..2^AW
- full  out  1  count == 2^AW
- busy  out  1  dump in progress (state != CAPTURE)

One clock; reset is asynchronous and active-low.

## Operation
- States: CAPTURE, READ, SEND.
- CAPTURE:
  - A write occurs when data_valid && capture_ready. It stores data_in at address count[AW-1:0], and count increments at the same edge.
  - capture_ready = !full. Results arriving while full are dropped silently and count does not change.
  - dump_start with effective count = 0 is ignored.
  - Effective count = count, plus 1 if a write occurs in the same cycle.
  - dump_start with effective count > 0 latches last = effective count − 1, clears rd_addr to 0 and the byte index to 0, and moves to READ.
  - A write in the same cycle as dump_start is stored and included in the dump.
- READ: one-cycle synchronous RAM read of rd_addr into the output word register, then go to SEND.
- SEND:
  - tx_valid = 1.
  - tx_data = word[W-1-8·k -: 8] for byte index k = 0..W/8-1.
  - On tx_valid && tx_ready, k increments.
  - After the handshake of byte k = W/8-1:
    - if rd_addr == last: count ← 0 and go to CAPTURE;
    - else rd_addr increments, k ← 0, and go to READ.
- During READ and SEND, capture_ready = 0, data_valid is ignored, and dump_start is ignored.
- RAM contents survive reset and dumps. Only count and the pointers are cleared.

## Timing
- Reset values: tx_valid=0, tx_data=0, count=0, full=0, busy=0, capture_ready=1. State is CAPTURE, rd_addr=0, k=0.
- Asserting rst_n low mid-dump aborts immediately. After release the block is in CAPTURE with count=0, and no further tx_valid appears.
- Write latency: count/full reflect a write at the edge it is accepted. full rises at the same edge as the 2^AW-th write.
- Dump latency: dump_start sampled at edge E. busy=1 after E (READ). tx_valid=1 after E+1 with byte 0.
- Handshake rules:
  - tx_data and tx_valid hold stable while tx_valid && !tx_ready.
  - tx_valid never drops without a handshake.
  - tx_valid drops for exactly one cycle (READ) between words.
- Throughput with tx_ready held at 1: W/8 + 1 cycles per word.
- End of dump: after the final handshake, tx_valid=0, busy=0, count=0, and capture_ready=1 on the next cycle.

## Test plan
- Reset/idle:
  - Stimulus: hold rst_n=0, then release.
  - Required: tx_valid=0, count=0, capture_ready=1. A dump_start pulse yields no tx_valid for 20 cycles.
- Basic dump (W=32):
  - Stimulus: write 0x11223344 then 0xAABBCCDD with tx_ready=1, then pulse dump_start.
  - Required byte sequence: 11 22 33 44, one-cycle gap, AA BB CC DD.
  - count ends at 0 and busy falls after the last byte.
- Backpressure:
  - Stimulus: during the dump, hold tx_ready=0 for 5 cycles on byte 2.
  - Required: tx_data stays 0x33 with tx_valid=1 throughout. The sequence resumes unchanged.
- Full:
  - Stimulus: write 1025 words with values 0..1024.
  - Required: full=1 and count=1024 after the 1024th word. Word 1024 is dropped.
  - The dump emits exactly 4096 bytes, ending 00 00 03 FF.
- Simultaneous write + dump_start:
  - Stimulus: count=3, and data_valid with 0xDEADBEEF in the same cycle as dump_start.
  - Required: 4 words dumped, the last being DE AD BE EF. data_valid is ignored during the dump.
- Reset mid-dump:
  - Stimulus: pull rst_n low during byte 1 of word 0.
  - Required: tx_valid=0 immediately and count=0.
  - A new write of 0x01020304 followed by a dump emits only 01 02 03 04.
